rps_match_ctrl: RTL
===================

RPS_MATCH_CTRL -- requirements
Module: rps_match_ctrl

Interface
REQ-001 SHALL have parameter ROCK, default 2'b00, rock hand encoding.
REQ-002 SHALL have parameter PAPER, default 2'b01, paper hand encoding.
REQ-003 SHALL have parameter SCISORS, default 2'b10, scissors hand encoding; 2'b11 is an invalid hand.
REQ-004 SHALL have parameter WIN_TARGET, default 3, points needed to win a match (1..2^SCORE_W-1).
REQ-005 SHALL have parameter SCORE_W, default 4, score width.
REQ-006 SHALL have these ports, in order:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; clears scores and begins a match.
- a_valid / a_hand / a_ready  in/in/out  1/2/1  player-A hand handshake.
- b_valid / b_hand / b_ready  in/in/out  1/2/1  player-B hand handshake.
- A, B  out  2  registered hands driven to the external combinational judge.
- is_A_win, is_error  in  1  judge outputs.
- round_done  out  1  one-cycle pulse when a round is scored.
- round_result  out  2  00 tie, 01 A wins, 10 B wins, 11 error.
- score_a, score_b  out  SCORE_W  current points.
- match_done  out  1  high while a match is finished.
- match_winner  out  1  0 = A, 1 = B; valid while match_done is high.

Function
REQ-007 SHALL implement the FSM IDLE -> COLLECT -> JUDGE -> REPORT -> (COLLECT | DONE); DONE and IDLE exit only on start.
REQ-008 On start in any state, SHALL on that edge clear the scores, discard captured hands, deassert match_done and enter COLLECT; start has priority over every handshake.
REQ-009 In COLLECT, a_ready SHALL be 1 until the A hand is captured (a_valid & a_ready at an edge), then 0; B SHALL behave independently the same way.
REQ-010 a_ready and b_ready SHALL be 0 in IDLE, JUDGE, REPORT and DONE.
REQ-011 A and B SHALL update at their capture edges and hold until the next capture.
REQ-012 SHALL enter JUDGE on the edge on which the second hand is captured; simultaneous capture of both hands is legal.
REQ-013 At the JUDGE-exit edge, SHALL register round_result with this priority:
- error if is_error, or either hand is 2'b11;
- else tie if A == B;
- else A wins if is_A_win;
- else B wins.
REQ-014 At the same edge, SHALL increment the winner's score; ties and errors leave both scores unchanged, except as stated in REQ-020.
REQ-015 round_done SHALL be high only during REPORT (exactly one cycle); latency is final capture edge N -> round_done high in the cycle after edge N+1.
REQ-016 From REPORT, SHALL go to DONE if either score equals WIN_TARGET, else to COLLECT.
REQ-017 In DONE, match_done and match_winner SHALL be held; the scores SHALL never exceed WIN_TARGET.

Reset
REQ-018 On reset low, SHALL immediately set:
- state IDLE; A = B = ROCK;
- scores 0; round_result 00;
- round_done, match_done, match_winner, a_ready, b_ready all 0.
REQ-019 Reset asserted mid-round SHALL discard all captured hands; no round_done is emitted.

Configuration
REQ-020 With RPS_ERROR_FORFEIT_EN defined:
- an error round in which exactly one hand is 2'b11 awards a point to the other player;
- round_result stays 11.
Without it, error rounds never change the scores.

Structure
REQ-021 Shared package rps_pkg SHALL hold the hand encodings, the round_result codes and the FSM state encoding.
REQ-022 Sub-module rps_hand_capture (valid/ready capture register plus captured flag) SHALL be instantiated once per player.

Verification
REQ-023 Reset, then start; A=PAPER, B=ROCK, same cycle, judge is_A_win=1 -> round_done 2 cycles later, round_result=01, score_a=1.
REQ-024 B hand 3 cycles before A hand, both SCISORS -> b_ready drops after B capture; round_result=00; scores unchanged.
REQ-025 B wins 3 consecutive rounds (WIN_TARGET=3) -> match_done=1, match_winner=1, score_b=3; ready stays 0 until start, then scores read 0.
REQ-026 A=2'b11, B=ROCK, is_error=1 -> round_result=11; score_b+1 with RPS_ERROR_FORFEIT_EN defined, unchanged without it.
REQ-027 reset low one cycle after the A capture -> all outputs at reset values at once; no round_done pulse.
REQ-028 start asserted in the same cycle as a_valid in COLLECT -> hand not captured, scores 0, a_ready=1 next cycle.

Source files
------------

// File: rtl/rps_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rps_pkg                                                              |
// | Shared hand encodings, round result codes and match FSM states.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rps_pkg;

  localparam logic [1:0] HAND_ROCK     = 2'b00;
  localparam logic [1:0] HAND_PAPER    = 2'b01;
  localparam logic [1:0] HAND_SCISSORS = 2'b10;
  localparam logic [1:0] HAND_INVALID  = 2'b11;

  localparam logic [1:0] RES_TIE   = 2'b00;
  localparam logic [1:0] RES_A_WIN = 2'b01;
  localparam logic [1:0] RES_B_WIN = 2'b10;
  localparam logic [1:0] RES_ERROR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_JUDGE   = 3'd2,
    ST_REPORT  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage : rps_pkg
`default_nettype wire

// File: rtl/rps_hand_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rps_hand_capture                                                     |
// | Valid/ready capture register with a captured flag, one per player.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rps_hand_capture #(
  parameter logic [1:0] RESET_HAND = 2'b00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_enable,
  input  logic       i_clear,
  input  logic       i_valid,
  input  logic [1:0] i_hand,
  output logic       o_ready,
  output logic [1:0] o_hand,
  output logic       o_captured,
  output logic       o_fire
);

  logic       r_captured;
  logic [1:0] r_hand;

  assign o_ready    = i_enable & ~r_captured;
  // A clear on the same edge wins so that start always beats the handshake.
  assign o_fire     = i_valid & o_ready & ~i_clear;
  assign o_hand     = r_hand;
  assign o_captured = r_captured;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_captured <= 1'b0;
      r_hand     <= RESET_HAND;
    end else if (i_clear) begin
      r_captured <= 1'b0;
    end else if (o_fire) begin
      r_captured <= 1'b1;
      r_hand     <= i_hand;
    end
  end

endmodule : rps_hand_capture
`default_nettype wire

// File: rtl/rps_match_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rps_match_ctrl                                                       |
// | Rock-paper-scissors match controller: collects both hands, scores    |
// | rounds from an external judge, ends the match at WIN_TARGET points.  |
// | Optional build macro: RPS_ERROR_FORFEIT_EN (invalid hand forfeits).  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rps_match_ctrl
  import rps_pkg::*;
#(
  parameter logic [1:0] ROCK       = HAND_ROCK,
  parameter logic [1:0] PAPER      = HAND_PAPER,
  parameter logic [1:0] SCISORS    = HAND_SCISSORS,
  parameter int         WIN_TARGET = 3,
  parameter int         SCORE_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               a_valid,
  input  logic [1:0]         a_hand,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [1:0]         b_hand,
  output logic               b_ready,
  output logic [1:0]         A,
  output logic [1:0]         B,
  input  logic               is_A_win,
  input  logic               is_error,
  output logic               round_done,
  output logic [1:0]         round_result,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               match_done,
  output logic               match_winner
);

  localparam logic [SCORE_W-1:0] c_WIN_TARGET = SCORE_W'(WIN_TARGET);

  state_t             r_state;
  state_t             w_next;
  logic [SCORE_W-1:0] r_score_a;
  logic [SCORE_W-1:0] r_score_b;
  logic [1:0]         r_result;
  logic               r_winner;

  logic w_enable;
  logic w_clear;
  logic w_a_cap;
  logic w_a_fire;
  logic w_b_cap;
  logic w_b_fire;
  logic w_bad_a;
  logic w_bad_b;
  logic [1:0] w_result;
  logic w_inc_a;
  logic w_inc_b;
  logic w_forfeit_a;
  logic w_forfeit_b;
  logic w_target_hit;

  function automatic logic f_hand_ok(input logic [1:0] h);
    return (h == ROCK) || (h == PAPER) || (h == SCISORS);
  endfunction

  assign w_enable = (r_state == ST_COLLECT);
  // Flags drop when the round is reported, so the next COLLECT starts empty.
  assign w_clear  = start | (r_state == ST_REPORT);

  rps_hand_capture #(.RESET_HAND(ROCK)) u_cap_a (
    .clk       (clk),
    .reset     (reset),
    .i_enable  (w_enable),
    .i_clear   (w_clear),
    .i_valid   (a_valid),
    .i_hand    (a_hand),
    .o_ready   (a_ready),
    .o_hand    (A),
    .o_captured(w_a_cap),
    .o_fire    (w_a_fire)
  );

  rps_hand_capture #(.RESET_HAND(ROCK)) u_cap_b (
    .clk       (clk),
    .reset     (reset),
    .i_enable  (w_enable),
    .i_clear   (w_clear),
    .i_valid   (b_valid),
    .i_hand    (b_hand),
    .o_ready   (b_ready),
    .o_hand    (B),
    .o_captured(w_b_cap),
    .o_fire    (w_b_fire)
  );

  assign w_bad_a      = ~f_hand_ok(A);
  assign w_bad_b      = ~f_hand_ok(B);
  assign w_target_hit = (r_score_a == c_WIN_TARGET) || (r_score_b == c_WIN_TARGET);

  always_comb begin
    w_result = RES_B_WIN;
    if (is_error || w_bad_a || w_bad_b) begin
      w_result = RES_ERROR;
    end else if (A == B) begin
      w_result = RES_TIE;
    end else if (is_A_win) begin
      w_result = RES_A_WIN;
    end
  end

`ifdef RPS_ERROR_FORFEIT_EN
  assign w_forfeit_a = (w_result == RES_ERROR) && w_bad_b && !w_bad_a;
  assign w_forfeit_b = (w_result == RES_ERROR) && w_bad_a && !w_bad_b;
`else
  assign w_forfeit_a = 1'b0;
  assign w_forfeit_b = 1'b0;
`endif

  assign w_inc_a = ((w_result == RES_A_WIN) || w_forfeit_a) && (r_score_a != c_WIN_TARGET);
  assign w_inc_b = ((w_result == RES_B_WIN) || w_forfeit_b) && (r_score_b != c_WIN_TARGET);

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = ST_COLLECT;
    end else begin
      unique case (r_state)
        ST_IDLE:    w_next = ST_IDLE;
        ST_COLLECT: if ((w_a_cap | w_a_fire) && (w_b_cap | w_b_fire)) w_next = ST_JUDGE;
        ST_JUDGE:   w_next = ST_REPORT;
        ST_REPORT:  w_next = w_target_hit ? ST_DONE : ST_COLLECT;
        ST_DONE:    w_next = ST_DONE;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_score_a <= '0;
      r_score_b <= '0;
      r_result  <= RES_TIE;
      r_winner  <= 1'b0;
    end else if (start) begin
      r_score_a <= '0;
      r_score_b <= '0;
      r_winner  <= 1'b0;
    end else if (r_state == ST_JUDGE) begin
      r_result <= w_result;
      if (w_inc_a) r_score_a <= r_score_a + 1'b1;
      if (w_inc_b) r_score_b <= r_score_b + 1'b1;
    end else if ((r_state == ST_REPORT) && w_target_hit) begin
      r_winner <= (r_score_b == c_WIN_TARGET);
    end
  end

  assign round_done   = (r_state == ST_REPORT);
  assign match_done   = (r_state == ST_DONE);
  assign match_winner = r_winner;
  assign round_result = r_result;
  assign score_a      = r_score_a;
  assign score_b      = r_score_b;

endmodule : rps_match_ctrl
`default_nettype wire
